// File: rtl/puf_resp_collector.sv
// rtl/puf_resp_collector.sv - three-sample PUF capture, 2-of-3 vote, 32-bit word streaming
// Also counts bits that disagreed across the three samples as a health metric.
module puf_resp_collector #(
  parameter int RESP_W        = 1024,
  parameter int WORD_W        = 32,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        challenge,
  output logic              busy,
  output logic              puf_enable,
  output logic [1:0]        puf_control,
  input  logic [RESP_W-1:0] puf_response,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic [4:0]        word_index,
  output logic              word_last,
  output logic              done,
  output logic [10:0]       unstable_cnt
);
  localparam int NUM_WORDS = RESP_W / WORD_W;
  localparam int CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       LAST_IDX    = 5'(NUM_WORDS - 1);

  // Sampling happens on the edge that ends the last ENABLE cycle, so CAPTURE is never entered.
  typedef enum logic [2:0] {IDLE, ENABLE, CAPTURE, RELAX, VOTE, STREAM} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [RESP_W-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [RESP_W-1:0] result_q, result_d, diff_q, diff_d;
  logic [4:0]        idx_q, idx_d;
  logic [10:0]       unstable_q, unstable_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] diff_word;
  logic [10:0]       diff_pop;

  always_comb begin
    diff_word = diff_q[int'(idx_q)*WORD_W +: WORD_W];
    diff_pop  = '0;
    for (int b = 0; b < WORD_W; b++) begin
      diff_pop = diff_pop + 11'(diff_word[b]);
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    k_d        = k_q;
    ctrl_d     = ctrl_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    result_d   = result_q;
    diff_d     = diff_q;
    idx_d      = idx_q;
    unstable_d = unstable_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ENABLE;
          ctrl_d     = challenge;
          unstable_d = '0;
          k_d        = '0;
          settle_d   = SETTLE_LAST;
        end
      end
      ENABLE: begin
        if (settle_q == '0) begin
          case (k_q)
            2'd0:    s0_d = puf_response;
            2'd1:    s1_d = puf_response;
            default: s2_d = puf_response;
          endcase
          state_d = (k_q == 2'd2) ? VOTE : RELAX;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end
      RELAX: begin
        k_d      = k_q + 2'd1;
        settle_d = SETTLE_LAST;
        state_d  = ENABLE;
      end
      VOTE: begin
        result_d = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
        diff_d   = (s0_q ^ s1_q) | (s0_q ^ s2_q);
        idx_d    = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        // done_q marks the extra STREAM cycle after the last handshake; start is still ignored here
        if (done_q) begin
          state_d = IDLE;
        end else if (word_ready) begin
          unstable_d = unstable_q + diff_pop;
          if (idx_q == LAST_IDX) begin
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      k_q        <= '0;
      ctrl_q     <= '0;
      s0_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      result_q   <= '0;
      diff_q     <= '0;
      idx_q      <= '0;
      unstable_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      k_q        <= k_d;
      ctrl_q     <= ctrl_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      result_q   <= result_d;
      diff_q     <= diff_d;
      idx_q      <= idx_d;
      unstable_q <= unstable_d;
      done_q     <= done_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign puf_enable   = (state_q == ENABLE);
  assign puf_control  = ctrl_q;
  assign word_valid   = (state_q == STREAM) && !done_q;
  assign word_data    = word_valid ? result_q[int'(idx_q)*WORD_W +: WORD_W] : '0;
  assign word_index   = word_valid ? idx_q : '0;
  assign word_last    = word_valid && (idx_q == LAST_IDX);
  assign done         = done_q;
  assign unstable_cnt = unstable_q;
endmodule
